// File: rtl/puf_cro_response.sv
// Response stage for the configurable ring oscillator PUF: runs the CRO under two
// challenges, counts synchronized rising edges per window and reports A-faster-than-B.
module puf_cro_response #(
    parameter int CHAL_W = 6,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 65536,
    parameter int SETTLE = 16,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAL_W-1:0] chal_a,
    input  logic [CHAL_W-1:0] chal_b,
    output logic [CHAL_W-1:0] cro_challenge,
    output logic              cro_en,
    input  logic              cro_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_bit,
    output logic              rsp_tie,
    output logic [CNT_W-1:0]  rsp_cnt_a,
    output logic [CNT_W-1:0]  rsp_cnt_b
);

    localparam int MAX_SG = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int MAX_T  = (WINDOW > MAX_SG) ? WINDOW : MAX_SG;
    localparam int TW     = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE_A,
        S_COUNT_A,
        S_GAP,
        S_SETTLE_B,
        S_COUNT_B,
        S_RESP
    } state_t;

    state_t             state;
    logic [TW-1:0]      timer;
    logic [CNT_W-1:0]   cnt_a;
    logic [CNT_W-1:0]   cnt_b;
    logic [CHAL_W-1:0]  chal_b_q;
    logic               ready_q;
    logic               s1;
    logic               s2;
    logic               s3;
    logic               rise;
    logic [CNT_W-1:0]   cnt_a_inc;
    logic [CNT_W-1:0]   cnt_b_inc;

    assign req_ready = ready_q & ~rst;
    assign rise      = s2 & ~s3;

    // Saturating increments; the B value feeds the compare so the last window edge is included.
    assign cnt_a_inc = (rise && (cnt_a != '1)) ? cnt_a + CNT_W'(1) : cnt_a;
    assign cnt_b_inc = (rise && (cnt_b != '1)) ? cnt_b + CNT_W'(1) : cnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            cnt_a         <= '0;
            cnt_b         <= '0;
            chal_b_q      <= '0;
            ready_q       <= 1'b1;
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            cro_en        <= 1'b0;
            cro_challenge <= '0;
            rsp_valid     <= 1'b0;
            rsp_bit       <= 1'b0;
            rsp_tie       <= 1'b0;
            rsp_cnt_a     <= '0;
            rsp_cnt_b     <= '0;
        end else begin
            s1 <= cro_o;
            s2 <= s1;
            s3 <= s2;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        chal_b_q      <= chal_b;
                        cnt_a         <= '0;
                        cnt_b         <= '0;
                        ready_q       <= 1'b0;
                        cro_en        <= 1'b1;
                        cro_challenge <= chal_a;
                        timer         <= TW'(SETTLE - 1);
                        state         <= S_SETTLE_A;
                    end
                end
                S_SETTLE_A: begin
                    if (timer == '0) begin
                        timer <= TW'(WINDOW - 1);
                        state <= S_COUNT_A;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_COUNT_A: begin
                    cnt_a <= cnt_a_inc;
                    if (timer == '0) begin
                        cro_en        <= 1'b0;
                        cro_challenge <= chal_b_q;
                        timer         <= TW'(GAP - 1);
                        state         <= S_GAP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        cro_en <= 1'b1;
                        timer  <= TW'(SETTLE - 1);
                        state  <= S_SETTLE_B;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_SETTLE_B: begin
                    if (timer == '0) begin
                        timer <= TW'(WINDOW - 1);
                        state <= S_COUNT_B;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_COUNT_B: begin
                    cnt_b <= cnt_b_inc;
                    if (timer == '0) begin
                        cro_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_bit   <= (cnt_a > cnt_b_inc);
                        rsp_tie   <= (cnt_a == cnt_b_inc);
                        rsp_cnt_a <= cnt_a;
                        rsp_cnt_b <= cnt_b_inc;
                        state     <= S_RESP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_cro_response.sv
// Bench for puf_cro_response: square-wave CRO stand-in, edge-history reference model,
// and a second 4-bit-counter instance sharing all stimulus to exercise saturation.
module tb_puf_cro_response;

    localparam int S    = 4;
    localparam int W    = 64;
    localparam int G    = 2;
    localparam int RESP_AT = 2*S + 2*W + G + 1;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [5:0] chal_a;
    logic [5:0] chal_b;
    logic       cro_o;
    logic       rsp_ready;

    logic       req_ready,     sat_req_ready;
    logic [5:0] cro_challenge, sat_cro_challenge;
    logic       cro_en,        sat_cro_en;
    logic       rsp_valid,     sat_rsp_valid;
    logic       rsp_bit,       sat_rsp_bit;
    logic       rsp_tie,       sat_rsp_tie;
    logic [7:0] rsp_cnt_a;
    logic [7:0] rsp_cnt_b;
    logic [3:0] sat_rsp_cnt_a;
    logic [3:0] sat_rsp_cnt_b;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  ph = 0;
    int  period = 0;
    bit  hist [0:16383];

    puf_cro_response #(.CHAL_W(6), .CNT_W(8), .WINDOW(W), .SETTLE(S), .GAP(G)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .chal_a(chal_a), .chal_b(chal_b), .cro_challenge(cro_challenge), .cro_en(cro_en),
        .cro_o(cro_o), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit),
        .rsp_tie(rsp_tie), .rsp_cnt_a(rsp_cnt_a), .rsp_cnt_b(rsp_cnt_b)
    );

    puf_cro_response #(.CHAL_W(6), .CNT_W(4), .WINDOW(W), .SETTLE(S), .GAP(G)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(sat_req_ready),
        .chal_a(chal_a), .chal_b(chal_b), .cro_challenge(sat_cro_challenge), .cro_en(sat_cro_en),
        .cro_o(cro_o), .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(sat_rsp_bit),
        .rsp_tie(sat_rsp_tie), .rsp_cnt_a(sat_rsp_cnt_a), .rsp_cnt_b(sat_rsp_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Half-clock-resolution square wave, offset so it never moves on a clock edge.
    initial begin
        cro_o = 1'b0;
        #3;
        forever begin
            cro_o = (period != 0) && ((ph % (2*period)) < period);
            ph = ph + 1;
            #5;
        end
    end

    always @(posedge clk) begin
        if (cyc < 16384) hist[cyc] <= cro_o;
        cyc <= cyc + 1;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: run did not finish (observed timeout, required completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A rise first sampled at edge k is counted at edge k+2 by the synchronizer/detector.
    function automatic int countRises(int first_count_edge, int last_count_edge);
        int n = 0;
        for (int k = first_count_edge - 2; k <= last_count_edge - 2; k++)
            if (hist[k] && !hist[k-1]) n++;
        return n;
    endfunction

    function automatic int sat(int n, int w);
        int m = (1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    task automatic applyStimulus(input string name, input logic [5:0] a, input logic [5:0] b,
                                 input int per_a, input int per_b, input bit align,
                                 input bit per_cycle, input int hold, input int rst_at,
                                 output int got_a8, output int got_b8);
        int a0, na, nb, ea8, eb8, ea4, eb4;
        got_a8 = 0;
        got_b8 = 0;
        checkOutput({name, "_req_ready"}, 32'(req_ready), 32'd1);
        chal_a = a;
        chal_b = b;
        req_valid = 1'b1;
        period = per_a;
        tick();
        req_valid = 1'b0;
        a0 = cyc - 1;
        if (align) ph = 0;
        for (int c = 1; c < RESP_AT; c++) begin
            if (c == S + W + 1) period = per_b;
            if (align && c == S + W + G + 1) ph = 0;
            if (c == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                #1;
                checkOutput({name, "_rst_cro_en"},    32'(cro_en),    32'd0);
                checkOutput({name, "_rst_req_ready"}, 32'(req_ready), 32'd1);
                checkOutput({name, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
                checkOutput({name, "_rst_rsp_cnt_a"}, 32'(rsp_cnt_a), 32'd0);
                return;
            end
            if (per_cycle) begin
                checkOutput($sformatf("%s_en_c%0d", name, c), 32'(cro_en),
                            32'((c > S + W && c <= S + W + G) ? 0 : 1));
                checkOutput($sformatf("%s_chal_c%0d", name, c), 32'(cro_challenge),
                            32'((c <= S + W) ? a : b));
                checkOutput($sformatf("%s_sat_en_c%0d", name, c), 32'(sat_cro_en),
                            32'((c > S + W && c <= S + W + G) ? 0 : 1));
                checkOutput($sformatf("%s_sat_chal_c%0d", name, c), 32'(sat_cro_challenge),
                            32'((c <= S + W) ? a : b));
                checkOutput($sformatf("%s_valid_c%0d", name, c), 32'(rsp_valid), 32'd0);
                checkOutput($sformatf("%s_ready_c%0d", name, c), 32'(req_ready), 32'd0);
            end
            tick();
        end
        na  = countRises(a0 + S + 1, a0 + S + W);
        nb  = countRises(a0 + 2*S + W + G + 1, a0 + 2*S + 2*W + G);
        ea8 = sat(na, 8);
        eb8 = sat(nb, 8);
        ea4 = sat(na, 4);
        eb4 = sat(nb, 4);
        got_a8 = 32'(rsp_cnt_a);
        got_b8 = 32'(rsp_cnt_b);
        checkOutput({name, "_rsp_valid"},  32'(rsp_valid), 32'd1);
        checkOutput({name, "_cro_en_off"}, 32'(cro_en),    32'd0);
        checkOutput({name, "_cnt_a"},      32'(rsp_cnt_a), 32'(ea8));
        checkOutput({name, "_cnt_b"},      32'(rsp_cnt_b), 32'(eb8));
        checkOutput({name, "_bit"},        32'(rsp_bit),   32'(ea8 > eb8));
        checkOutput({name, "_tie"},        32'(rsp_tie),   32'(ea8 == eb8));
        checkOutput({name, "_sat_valid"},  32'(sat_rsp_valid), 32'd1);
        checkOutput({name, "_sat_cnt_a"},  32'(sat_rsp_cnt_a), 32'(ea4));
        checkOutput({name, "_sat_cnt_b"},  32'(sat_rsp_cnt_b), 32'(eb4));
        checkOutput({name, "_sat_bit"},    32'(sat_rsp_bit),   32'(ea4 > eb4));
        checkOutput({name, "_sat_tie"},    32'(sat_rsp_tie),   32'(ea4 == eb4));
        for (int h = 0; h < hold; h++) begin
            req_valid = h[0];
            chal_a = 6'($urandom);
            chal_b = 6'($urandom);
            tick();
            checkOutput($sformatf("%s_hold_valid_%0d", name, h), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("%s_hold_ready_%0d", name, h), 32'(req_ready), 32'd0);
            checkOutput($sformatf("%s_hold_en_%0d", name, h),    32'(cro_en),    32'd0);
            checkOutput($sformatf("%s_hold_cnt_a_%0d", name, h), 32'(rsp_cnt_a), 32'(ea8));
            checkOutput($sformatf("%s_hold_cnt_b_%0d", name, h), 32'(rsp_cnt_b), 32'(eb8));
            checkOutput($sformatf("%s_hold_bit_%0d", name, h),   32'(rsp_bit),   32'(ea8 > eb8));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({name, "_done_ready"}, 32'(req_ready), 32'd1);
        checkOutput({name, "_done_cnt_a"}, 32'(rsp_cnt_a), 32'(ea8));
    endtask

    initial begin
        int ca, cb;
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chal_a = '0;
        chal_b = '0;
        tick();
        tick();
        checkOutput("reset_req_ready_low", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("reset_req_ready",  32'(req_ready),     32'd1);
        checkOutput("reset_cro_en",     32'(cro_en),        32'd0);
        checkOutput("reset_challenge",  32'(cro_challenge), 32'd0);
        checkOutput("reset_rsp_valid",  32'(rsp_valid),     32'd0);
        checkOutput("reset_rsp_bit",    32'(rsp_bit),       32'd0);
        checkOutput("reset_rsp_tie",    32'(rsp_tie),       32'd0);
        checkOutput("reset_rsp_cnt_a",  32'(rsp_cnt_a),     32'd0);
        checkOutput("reset_rsp_cnt_b",  32'(rsp_cnt_b),     32'd0);

        $display("[TB] A faster than B, per-cycle enable/challenge trace");
        applyStimulus("t1", 6'h15, 6'h2A, 4, 8, 1'b0, 1'b1, 0, 0, ca, cb);
        checkOutput("t1_cnt_a_near16", 32'(ca >= 15 && ca <= 17), 32'd1);
        checkOutput("t1_cnt_b_near8",  32'(cb >= 7 && cb <= 9),   32'd1);
        checkOutput("t1_bit_one",      32'(rsp_bit),              32'd1);

        $display("[TB] equal aligned periods");
        applyStimulus("t2", 6'h0F, 6'h30, 6, 6, 1'b1, 1'b0, 0, 0, ca, cb);
        checkOutput("t2_tie_one", 32'(rsp_tie), 32'd1);
        checkOutput("t2_bit_zero", 32'(rsp_bit), 32'd0);

        $display("[TB] saturation with fast oscillator");
        applyStimulus("t3", 6'h01, 6'h3E, 3, 3, 1'b1, 1'b0, 0, 0, ca, cb);
        checkOutput("t3_sat_a15", 32'(sat_rsp_cnt_a), 32'd15);
        checkOutput("t3_sat_b15", 32'(sat_rsp_cnt_b), 32'd15);
        checkOutput("t3_sat_tie", 32'(sat_rsp_tie),   32'd1);

        $display("[TB] response backpressure");
        applyStimulus("t4", 6'h22, 6'h11, 5, 7, 1'b0, 1'b0, 20, 0, ca, cb);

        $display("[TB] reset during second count, then fresh request");
        applyStimulus("t5r", 6'h33, 6'h0C, 5, 5, 1'b0, 1'b0, 0, 2*S + W + G + 10, ca, cb);
        tick();
        applyStimulus("t5", 6'h33, 6'h0C, 9, 4, 1'b0, 1'b1, 0, 0, ca, cb);

        $display("[TB] randomized requests");
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("rnd%0d", i), 6'($urandom), 6'($urandom),
                          int'($urandom_range(3, 10)), int'($urandom_range(3, 10)),
                          1'b0, 1'b0, int'($urandom_range(0, 3)), 0, ca, cb);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
